piso_shift_tx: RTL

//   Parallel-in serial-out transmitter. Accepts a DATA_W-bit word over a valid/ready

---
 rtl/piso_shift_tx.sv | 107 ++++++++++
 1 files changed

// File: rtl/piso_shift_tx.sv
// rtl/piso_shift_tx.sv - parallel-in serial-out transmitter with valid/ready word input
module piso_shift_tx #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              shift_en,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              busy
);

    localparam int              CW   = $clog2(DATA_W);
    localparam logic [CW-1:0]   LAST = CW'(DATA_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nx;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nx;
    logic              take;
    logic              frame_nx;
    logic              ser_out_nx;
    logic              ser_last_nx;

    // A new word is accepted when idle, or on the final bit of a frame that is advancing,
    // so consecutive frames run without a gap.
    assign in_ready = (state == IDLE) | ((state == SHIFT) & (cnt == LAST) & shift_en);
    assign take     = in_valid & in_ready;

    // State, shift register, counter and registered serial outputs; reset wins over all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            shreg     <= shreg_nx;
            cnt       <= cnt_nx;
            ser_out   <= ser_out_nx;
            ser_valid <= frame_nx;
            ser_last  <= ser_last_nx;
            busy      <= frame_nx;
        end
    end

    // Next-state logic: load on handshake, advance one bit per enabled cycle, end or chain.
    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (take) begin
                    state_nx = SHIFT;
                    shreg_nx = in_data;
                    cnt_nx   = '0;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (cnt == LAST) begin
                        cnt_nx = '0;
                        if (take) begin
                            shreg_nx = in_data;
                        end else begin
                            state_nx = IDLE;
                            shreg_nx = '0;
                        end
                    end else begin
                        cnt_nx   = cnt + 1'b1;
                        shreg_nx = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                shreg_nx = '0;
                cnt_nx   = '0;
            end
        endcase
    end

    // Output decode from next-state values so the serial outputs come straight from flops.
    always_comb begin
        frame_nx    = (state_nx == SHIFT);
        ser_out_nx  = frame_nx & (MSB_FIRST ? shreg_nx[DATA_W-1] : shreg_nx[0]);
        ser_last_nx = frame_nx & (cnt_nx == LAST);
    end

endmodule
